// File: rtl/step_arb_pkg.sv
// Shared types and constants for the step-engine job arbiter.
package step_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int TMR_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/step_job_arbiter_rr_pick.sv
// Rotating-priority encoder: picks the first requester after last_grant.
module rr_pick
  import step_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               any_valid
);

  // Scan farthest-first so the nearest candidate after last_grant overwrites.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_REQ]) begin
        grant     = IW'((int'(last_grant) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_job_arbiter.sv
// Round-robin sharing of one start/done step engine among NUM_REQ clients.
// Optional WAIT timeout is enabled by defining STEP_ARB_TIMEOUT_EN.
module step_job_arbiter
  import step_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_data_in,
  input  logic [DATA_W-1:0]         eng_data_out,
  input  logic                      eng_done
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              state_reg, state_next;
  logic [IW-1:0]       last_grant_reg, last_grant_next;
  logic [IW-1:0]       gnt_id_reg, gnt_id_next;
  logic [DATA_W-1:0]   job_reg, job_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic [IW-1:0]       pick;
  logic                any_valid;

`ifdef STEP_ARB_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0]    cnt_reg, cnt_next;
  logic                rsp_err_reg, rsp_err_next;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (pick),
    .any_valid  (any_valid)
  );

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    gnt_id_next     = gnt_id_reg;
    job_next        = job_reg;
    rsp_data_next   = rsp_data_reg;
`ifdef STEP_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    rsp_err_next    = rsp_err_reg;
`endif
    req_ready       = '0;
    rsp_valid       = '0;
    eng_start       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          // Keep req_ready low while reset is held so no handshake is implied.
          req_ready[pick] = !rst;
          job_next        = req_data[int'(pick)*DATA_W +: DATA_W];
          gnt_id_next     = pick;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        eng_start  = 1'b1;
        state_next = WAIT;
`ifdef STEP_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      WAIT: begin
        if (eng_done) begin
          rsp_data_next = eng_data_out;
`ifdef STEP_ARB_TIMEOUT_EN
          rsp_err_next  = 1'b0;
`endif
          state_next    = RESP;
        end
`ifdef STEP_ARB_TIMEOUT_EN
        else if (cnt_reg == TMO_LAST) begin
          rsp_data_next = '0;
          rsp_err_next  = 1'b1;
          state_next    = RESP;
        end else begin
          cnt_next = cnt_reg + TMR_W'(1);
        end
`endif
      end
      RESP: begin
        rsp_valid[gnt_id_reg] = 1'b1;
        if (rsp_ready[gnt_id_reg]) begin
          last_grant_next = gnt_id_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NUM_REQ - 1);
      gnt_id_reg     <= '0;
      job_reg        <= '0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      gnt_id_reg     <= gnt_id_next;
      job_reg        <= job_next;
      rsp_data_reg   <= rsp_data_next;
    end
  end

`ifdef STEP_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      rsp_err_reg <= rsp_err_next;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_data    = rsp_data_reg;
  assign eng_data_in = job_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: doc/step_job_arbiter.md
Name: step_job_arbiter

Overview:
- Shares one step-controller engine (start/data_in -> data_out/done pulse) between NUM_REQ independent requesters.
- Grants access round-robin and runs one job at a time: accept, start engine, wait for done, return result to the granted requester.
- Sits between client blocks and the single engine instance; the engine is not modified.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, job data / result width; must match engine.
- TIMEOUT, 255, max cycles waited for eng_done (used only with STEP_ARB_TIMEOUT_EN), 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_data  in  NUM_REQ*DATA_W  per-requester operand; slice i = bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i]&req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot result valid, held until taken.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DATA_W  result, valid for the requester flagged in rsp_valid.
- rsp_err  out  1  result is a timeout error (tied 0 without macro).
- busy  out  1  high whenever state != IDLE.
- eng_start  out  1  engine start pulse.
- eng_data_in  out  DATA_W  engine operand.
- eng_data_out  in  DATA_W  engine result.
- eng_done  in  1  engine single-cycle completion pulse.

Behaviour:
- Clock is clk. Reset is rst, asynchronous, active-high.
- Reset values:
  - all outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority; data and result registers 0.
  - Reset mid-job abandons the job; no response is issued. The engine is not reset by this block.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready = onehot(grant), combinational, only in IDLE; 0 when no valid.
  - On transfer: latch req_data slice into job_reg and grant into gnt_id; next state ISSUE.
- ISSUE:
  - eng_start = 1 for exactly one cycle; eng_data_in = job_reg.
  - eng_data_in holds job_reg in all states.
  - Next state WAIT.
- WAIT:
  - On eng_done: latch eng_data_out into rsp_data, rsp_err = 0; next state RESP.
  - eng_done in IDLE/ISSUE/RESP is ignored.
- RESP:
  - rsp_valid[gnt_id] = 1; rsp_data and rsp_err stable.
  - On rsp_ready[gnt_id]: last_grant <= gnt_id; next state IDLE.
  - rsp_ready of other requesters is ignored.
- Latency:
  - accept cycle T -> eng_start at T+1.
  - eng_done at cycle D -> rsp_valid at D+1.
  - rsp handshake at cycle R -> next req_ready possible at R+1.
  - Minimum of 1 idle cycle between jobs.
- Only one job is in flight; no queuing. Requesters not granted keep req_valid asserted.
- Fairness: a requester re-requesting immediately yields to any other pending requester. Worst-case wait is NUM_REQ-1 jobs.
- A requester deasserting req_valid before the handshake is legal; it is simply not granted.

Optional Feature:
- Macro: STEP_ARB_TIMEOUT_EN.
- With macro:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without eng_done: go to RESP with rsp_data = 0, rsp_err = 1.
  - eng_done in the same cycle as the timeout wins: normal result, rsp_err = 0.
  - A late eng_done after a timeout is ignored.
- Without macro: no counter; WAIT waits indefinitely; rsp_err constant 0.

Decomposition:
- Package step_arb_pkg:
  - state encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3.
  - default DATA_W / NUM_REQ constants.
  - timeout counter width (16).
- One sub-module, rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_valid.
- FSM, registers and engine interface live in step_job_arbiter.

Test Plan:
- Single job: req_valid[2] = 1, data 0x05; engine model returns 0x2A after 6 cycles -> req_ready[2] at T, eng_start at T+1 with eng_data_in = 0x05, rsp_valid[2] with rsp_data = 0x2A one cycle after eng_done, busy low after rsp_ready[2].
- Round-robin: all four requesters held valid for 8 jobs -> grant order 0,1,2,3,0,1,2,3, exactly one eng_start per job.
- Backpressure: rsp_ready[1] held low for 10 cycles -> rsp_valid[1] and rsp_data stable; no req_ready asserted; no eng_start.
- Reset mid-job: rst asserted during WAIT -> all outputs 0 immediately; after release, requester 0 is granted first.
- Spurious done: eng_done pulsed in IDLE and RESP -> no state change, rsp_data unchanged.
- With STEP_ARB_TIMEOUT_EN and TIMEOUT = 20: engine never responds -> rsp_valid with rsp_err = 1, rsp_data = 0 exactly 20 WAIT cycles after entering WAIT. Repeat with eng_done on cycle 20 -> rsp_err = 0 and the real data is returned.
